// File: rtl/nvram_autosave.sv
// nvram_autosave: pauses the CPU every few frames, scans the core NVRAM into a shadow RAM and
// requests a save on change; serves ioctl uploads/downloads from the shadow. Option: NVRAM_SKIP_BLANK_EN.
module nvram_autosave #(
    parameter int DUMPWIDTH     = 6,
    parameter int DUMPINDEX     = 4,
    parameter int PAUSEPAD      = 2,
    parameter int CHECK_FRAMES  = 60,
    parameter int PAUSE_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 vblank,
    input  logic                 autosave,
    input  logic                 paused,
    output logic                 pause_cpu,
    output logic [DUMPWIDTH-1:0] nvram_address,
    input  logic [7:0]           nvram_data_in,
    input  logic                 ioctl_download,
    input  logic                 ioctl_upload,
    input  logic                 ioctl_wr,
    input  logic [7:0]           ioctl_index,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic [7:0]           ioctl_din,
    output logic                 ioctl_upload_req,
    output logic                 dirty
);

    localparam int DEPTH = 1 << DUMPWIDTH;
    localparam int TO_W  = $clog2(PAUSE_TIMEOUT + 1);
    localparam int PAD_W = (PAUSEPAD > 1) ? $clog2(PAUSEPAD) : 1;

    localparam logic [7:0]           FRAME_LAST = 8'(CHECK_FRAMES - 1);
    localparam logic [7:0]           DUMP_IDX   = 8'(DUMPINDEX);
    localparam logic [TO_W-1:0]      TO_LAST    = TO_W'(PAUSE_TIMEOUT - 1);
    localparam logic [TO_W-1:0]      TO_ONE     = TO_W'(1);
    localparam logic [PAD_W-1:0]     PAD_LAST   = PAD_W'(PAUSEPAD - 1);
    localparam logic [PAD_W-1:0]     PAD_ONE    = PAD_W'(1);
    localparam logic [DUMPWIDTH:0]   SCAN_LAST  = (DUMPWIDTH + 1)'(DEPTH);
    localparam logic [DUMPWIDTH:0]   SCAN_ONE   = (DUMPWIDTH + 1)'(1);
    localparam logic [DUMPWIDTH:0]   SCAN_ZERO  = {(DUMPWIDTH + 1){1'b0}};
    localparam logic [DUMPWIDTH-1:0] ADDR_ZERO  = {DUMPWIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_PAD  = 3'd2,
        ST_SCAN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t               state_r;
    logic [7:0]           frame_cnt_r;
    logic [TO_W-1:0]      to_cnt_r;
    logic [PAD_W-1:0]     pad_cnt_r;
    logic [DUMPWIDTH:0]   scan_cnt_r;
    logic                 vblank_d_r;
    logic                 upload_d_r;
    logic [7:0]           shadow_r [DEPTH];

    logic                 vblank_rise_s;
    logic                 upload_rise_s;
    logic                 upload_fall_s;
    logic                 xfer_active_s;
    logic                 dl_wr_s;
    logic [DUMPWIDTH:0]   scan_prev_s;
    logic [DUMPWIDTH:0]   scan_next_s;
    logic [DUMPWIDTH-1:0] cmp_addr_s;
    logic                 cmp_valid_s;
    logic                 scan_diff_s;
    logic                 dirty_next_s;
    logic                 wr_en_s;
    logic [DUMPWIDTH-1:0] wr_addr_s;
    logic [7:0]           wr_data_s;
    logic                 unused_s;

    assign vblank_rise_s = vblank & ~vblank_d_r;
    assign upload_rise_s = ioctl_upload & ~upload_d_r;
    assign upload_fall_s = ~ioctl_upload & upload_d_r;
    assign xfer_active_s = ioctl_download | ioctl_upload;
    assign dl_wr_s       = ioctl_download & ioctl_wr & (ioctl_index == DUMP_IDX);
    assign unused_s      = ^ioctl_addr[24:DUMPWIDTH];

    // The byte compared this cycle is the one addressed on the previous scan cycle.
    assign scan_prev_s  = scan_cnt_r - SCAN_ONE;
    assign scan_next_s  = scan_cnt_r + SCAN_ONE;
    assign cmp_addr_s   = scan_prev_s[DUMPWIDTH-1:0];
    assign cmp_valid_s  = (state_r == ST_SCAN) && (scan_cnt_r != SCAN_ZERO) && !xfer_active_s;
    assign scan_diff_s  = cmp_valid_s && (nvram_data_in != shadow_r[cmp_addr_s]);
    assign dirty_next_s = dirty | scan_diff_s;

`ifdef NVRAM_SKIP_BLANK_EN
    logic all_zero_r;
    logic all_ff_r;
    logic zero_next_s;
    logic ff_next_s;
    logic blank_s;

    assign zero_next_s = all_zero_r & (~cmp_valid_s | (nvram_data_in == 8'h00));
    assign ff_next_s   = all_ff_r & (~cmp_valid_s | (nvram_data_in == 8'hFF));
    assign blank_s     = zero_next_s | ff_next_s;

    // Track whether every byte compared so far in this scan is uniformly blank.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            all_zero_r <= 1'b1;
            all_ff_r   <= 1'b1;
        end else if (state_r != ST_SCAN) begin
            all_zero_r <= 1'b1;
            all_ff_r   <= 1'b1;
        end else begin
            all_zero_r <= zero_next_s;
            all_ff_r   <= ff_next_s;
        end
    end
`endif

    // Single shadow write port; host downloads win over the scan.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = ADDR_ZERO;
        wr_data_s = 8'h00;
        if (dl_wr_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = ioctl_addr[DUMPWIDTH-1:0];
            wr_data_s = ioctl_dout;
        end else if (scan_diff_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = cmp_addr_s;
            wr_data_s = nvram_data_in;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Shadow RAM storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            shadow_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Control FSM, frame counting, request/dirty flags and upload read port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            pause_cpu        <= 1'b0;
            nvram_address    <= ADDR_ZERO;
            ioctl_din        <= 8'h00;
            ioctl_upload_req <= 1'b0;
            dirty            <= 1'b0;
            frame_cnt_r      <= 8'd0;
            to_cnt_r         <= {TO_W{1'b0}};
            pad_cnt_r        <= {PAD_W{1'b0}};
            scan_cnt_r       <= SCAN_ZERO;
            vblank_d_r       <= vblank;
            upload_d_r       <= ioctl_upload;
        end else begin
            vblank_d_r <= vblank;
            upload_d_r <= ioctl_upload;
            ioctl_din  <= shadow_r[ioctl_addr[DUMPWIDTH-1:0]];

            if (upload_rise_s) begin
                ioctl_upload_req <= 1'b0;
            end
            if (upload_fall_s && (ioctl_index == DUMP_IDX)) begin
                dirty <= 1'b0;
            end else if (scan_diff_s) begin
                dirty <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    nvram_address <= ADDR_ZERO;
                    if (vblank_rise_s) begin
                        if (frame_cnt_r == FRAME_LAST) begin
                            frame_cnt_r <= 8'd0;
                            if (autosave && !xfer_active_s) begin
                                state_r   <= ST_REQ;
                                pause_cpu <= 1'b1;
                                to_cnt_r  <= {TO_W{1'b0}};
                            end
                        end else begin
                            frame_cnt_r <= frame_cnt_r + 8'd1;
                        end
                    end
                end
                ST_REQ: begin
                    if (xfer_active_s) begin
                        state_r   <= ST_IDLE;
                        pause_cpu <= 1'b0;
                    end else if (paused) begin
                        pad_cnt_r  <= {PAD_W{1'b0}};
                        scan_cnt_r <= SCAN_ZERO;
                        state_r    <= (PAUSEPAD == 0) ? ST_SCAN : ST_PAD;
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r   <= ST_IDLE;
                        pause_cpu <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end
                end
                ST_PAD: begin
                    if (xfer_active_s) begin
                        state_r   <= ST_IDLE;
                        pause_cpu <= 1'b0;
                    end else if (pad_cnt_r == PAD_LAST) begin
                        state_r <= ST_SCAN;
                    end else begin
                        pad_cnt_r <= pad_cnt_r + PAD_ONE;
                    end
                end
                ST_SCAN: begin
                    if (xfer_active_s) begin
                        state_r       <= ST_IDLE;
                        pause_cpu     <= 1'b0;
                        nvram_address <= ADDR_ZERO;
                    end else if (scan_cnt_r == SCAN_LAST) begin
                        state_r       <= ST_DONE;
                        pause_cpu     <= 1'b0;
                        nvram_address <= ADDR_ZERO;
`ifdef NVRAM_SKIP_BLANK_EN
                        if (blank_s) begin
                            dirty <= 1'b0;
                        end else if (dirty_next_s) begin
                            ioctl_upload_req <= 1'b1;
                        end
`else
                        if (dirty_next_s) begin
                            ioctl_upload_req <= 1'b1;
                        end
`endif
                    end else begin
                        nvram_address <= scan_next_s[DUMPWIDTH-1:0];
                        scan_cnt_r    <= scan_next_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pause_cpu <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nvram_autosave.sv
// Self-checking bench for nvram_autosave: random shadow/core images checked against a
// whole-image reference model; honours NVRAM_SKIP_BLANK_EN when defined.
module tb_nvram_autosave;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vblank = 1'b0;
    logic        autosave = 1'b0;
    logic        paused = 1'b0;
    logic        pause_cpu;
    logic [5:0]  nvram_address;
    logic [7:0]  nvram_data_in = 8'h00;
    logic        ioctl_download = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic [7:0]  ioctl_din;
    logic        ioctl_upload_req;
    logic        dirty;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_sh   [N];
    logic [7:0] core_mem [N];
    bit         exp_dirty = 1'b0;
    bit         exp_req = 1'b0;

    nvram_autosave #(
        .DUMPWIDTH(6), .DUMPINDEX(4), .PAUSEPAD(2), .CHECK_FRAMES(3), .PAUSE_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vblank(vblank), .autosave(autosave), .paused(paused),
        .pause_cpu(pause_cpu), .nvram_address(nvram_address), .nvram_data_in(nvram_data_in),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din), .ioctl_upload_req(ioctl_upload_req), .dirty(dirty)
    );

    always #5 clk = ~clk;

    // Core NVRAM: data appears one cycle after the address.
    always @(posedge clk) nvram_data_in <= core_mem[nvram_address];

    // Reference: effect of one complete scan on the shadow image and flags.
    task automatic model_full_scan();
        bit changed;
        bit all_zero;
        bit all_ff;
        changed = 1'b0; all_zero = 1'b1; all_ff = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (core_mem[k] != exp_sh[k]) begin
                exp_sh[k] = core_mem[k];
                changed = 1'b1;
            end
            if (core_mem[k] != 8'h00) all_zero = 1'b0;
            if (core_mem[k] != 8'hFF) all_ff = 1'b0;
        end
        exp_dirty = exp_dirty | changed;
`ifdef NVRAM_SKIP_BLANK_EN
        if (all_zero || all_ff) exp_dirty = 1'b0;
        else if (exp_dirty) exp_req = 1'b1;
`else
        if (exp_dirty) exp_req = 1'b1;
`endif
    endtask

    task automatic vblank_pulse();
        @(negedge clk); vblank = 1'b1;
        @(negedge clk); vblank = 1'b0;
        @(negedge clk);
    endtask

    // Three vblank edges, then watch the pause window; optional mid-window actions.
    task automatic run_check(input bit give_paused, input int vb_at, input int abort_at,
                             input int reset_at, output int high, output int addr_moves);
        high = 0; addr_moves = 0;
        vblank_pulse();
        vblank_pulse();
        @(negedge clk); vblank = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            vblank = 1'b0;
            if (pause_cpu) begin
                high++;
                if (nvram_address != 6'd0) addr_moves++;
                if (give_paused && high == 2) paused = 1'b1;
                if (high == vb_at) vblank = 1'b1;
                if (high == abort_at) begin
                    ioctl_download = 1'b1; ioctl_index = 8'd4; ioctl_wr = 1'b1;
                    ioctl_addr = {19'($urandom()), 6'h05}; ioctl_dout = 8'h3C;
                end
                if (high == reset_at) begin
                    checks++;
                    if (dirty !== 1'b1) begin errors++; $display("FAIL dirty_before_reset: got %b want 1", dirty); end
                    reset_n = 1'b0;
                end
            end else if (high > 0) begin
                break;
            end
        end
        paused = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pause_cpu, ioctl_upload_req, dirty, nvram_address, ioctl_din} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: pause=%b req=%b dirty=%b addr=%h din=%h want all 0",
                     pause_cpu, ioctl_upload_req, dirty, nvram_address, ioctl_din);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({pause_cpu, ioctl_upload_req, dirty} !== 3'b000) begin
            errors++; $display("FAIL after_reset: pause=%b req=%b dirty=%b want 000", pause_cpu, ioctl_upload_req, dirty);
        end
    endtask

    task automatic test_download(input bit zeros);
        @(negedge clk);
        ioctl_download = 1'b1; ioctl_index = 8'd4; ioctl_wr = 1'b1;
        for (int k = 0; k < N; k++) begin
            ioctl_addr = {19'($urandom()), 6'(k)};
            ioctl_dout = zeros ? 8'h00 : ((k == 8'h17) ? 8'h11 : 8'($urandom()));
            exp_sh[k] = ioctl_dout;
            @(negedge clk);
        end
        // Wrong index must not touch the shadow.
        ioctl_index = 8'd5; ioctl_addr = 25'd3; ioctl_dout = ~exp_sh[3];
        @(negedge clk);
        ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
        @(negedge clk);
        checks++;
        if (dirty !== exp_dirty || ioctl_upload_req !== exp_req) begin
            errors++; $display("FAIL download_flags: dirty=%b req=%b want %b %b", dirty, ioctl_upload_req, exp_dirty, exp_req);
        end
    endtask

    task automatic test_upload();
        @(negedge clk);
        checks++;
        if (ioctl_upload_req !== exp_req) begin
            errors++; $display("FAIL req_before_upload: got %b want %b", ioctl_upload_req, exp_req);
        end
        ioctl_index = 8'd4; ioctl_upload = 1'b1; ioctl_addr = 25'd0;
        @(negedge clk);
        exp_req = 1'b0;
        checks++;
        if (ioctl_upload_req !== 1'b0 || dirty !== exp_dirty) begin
            errors++; $display("FAIL upload_start: req=%b dirty=%b want 0 %b", ioctl_upload_req, dirty, exp_dirty);
        end
        for (int k = 0; k < N; k++) begin
            ioctl_addr = {19'($urandom()), 6'(k)};
            @(negedge clk);
            checks++;
            if (ioctl_din !== exp_sh[k]) begin
                errors++; $display("FAIL upload_data[%0d]: got %h want %h", k, ioctl_din, exp_sh[k]);
            end
        end
        ioctl_upload = 1'b0;
        @(negedge clk);
        exp_dirty = 1'b0;
        checks++;
        if (dirty !== 1'b0) begin
            errors++; $display("FAIL dirty_after_upload: got %b want 0", dirty);
        end
        ioctl_index = 8'd0;
    endtask

    task automatic test_autosave_off();
        int high, moves;
        autosave = 1'b0;
        run_check(1'b1, 0, 0, 0, high, moves);
        checks++;
        if (high != 0) begin errors++; $display("FAIL autosave_off_pause: got %0d cycles want 0", high); end
        autosave = 1'b1;
    endtask

    task automatic test_scan_clean();
        int high, moves;
        for (int k = 0; k < N; k++) core_mem[k] = exp_sh[k];
        run_check(1'b1, 30, 0, 0, high, moves);
        model_full_scan();
        repeat (2) @(negedge clk);
        checks++;
        if (high != 69) begin errors++; $display("FAIL clean_pause_len: got %0d want 69", high); end
        checks++;
        if (moves != 63) begin errors++; $display("FAIL clean_addr_moves: got %0d want 63", moves); end
        checks++;
        if (ioctl_upload_req !== exp_req || dirty !== exp_dirty) begin
            errors++; $display("FAIL clean_flags: req=%b dirty=%b want %b %b", ioctl_upload_req, dirty, exp_req, exp_dirty);
        end
    endtask

    task automatic test_scan_dirty();
        int high, moves;
        for (int k = 0; k < N; k++) core_mem[k] = exp_sh[k];
        core_mem[8'h17] = 8'hA5;
        for (int i = 0; i < 3; i++) core_mem[$urandom_range(32, 63)] = 8'($urandom());
        run_check(1'b1, 0, 0, 0, high, moves);
        model_full_scan();
        repeat (2) @(negedge clk);
        checks++;
        if (high != 69) begin errors++; $display("FAIL dirty_pause_len: got %0d want 69", high); end
        checks++;
        if (ioctl_upload_req !== exp_req || dirty !== exp_dirty) begin
            errors++; $display("FAIL dirty_flags: req=%b dirty=%b want %b %b", ioctl_upload_req, dirty, exp_req, exp_dirty);
        end
    endtask

    task automatic test_download_abort();
        int high, moves;
        run_check(1'b1, 0, 20, 0, high, moves);
        exp_sh[5] = 8'h3C;
        repeat (2) @(negedge clk);
        checks++;
        if (high != 20) begin errors++; $display("FAIL abort_pause_len: got %0d want 20", high); end
        checks++;
        if (pause_cpu !== 1'b0 || ioctl_upload_req !== exp_req || dirty !== exp_dirty) begin
            errors++; $display("FAIL abort_flags: pause=%b req=%b dirty=%b want 0 %b %b",
                               pause_cpu, ioctl_upload_req, dirty, exp_req, exp_dirty);
        end
    endtask

    task automatic test_timeout();
        int high, moves;
        run_check(1'b0, 0, 0, 0, high, moves);
        repeat (2) @(negedge clk);
        checks++;
        if (high != 16) begin errors++; $display("FAIL timeout_len: got %0d want 16", high); end
        checks++;
        if (moves != 0) begin errors++; $display("FAIL timeout_addr: got %0d moves want 0", moves); end
        checks++;
        if (ioctl_upload_req !== exp_req || dirty !== exp_dirty) begin
            errors++; $display("FAIL timeout_flags: req=%b dirty=%b want %b %b", ioctl_upload_req, dirty, exp_req, exp_dirty);
        end
    endtask

    task automatic test_blank();
        int high, moves;
        test_download(1'b1);
        for (int k = 0; k < N; k++) core_mem[k] = 8'hFF;
        run_check(1'b1, 0, 0, 0, high, moves);
        model_full_scan();
        repeat (2) @(negedge clk);
        checks++;
        if (high != 69) begin errors++; $display("FAIL blank_pause_len: got %0d want 69", high); end
        checks++;
        if (ioctl_upload_req !== exp_req || dirty !== exp_dirty) begin
            errors++; $display("FAIL blank_flags: req=%b dirty=%b want %b %b", ioctl_upload_req, dirty, exp_req, exp_dirty);
        end
        test_upload();
    endtask

    task automatic test_reset_mid_scan();
        int high, moves;
        for (int k = 0; k < N; k++) core_mem[k] = exp_sh[k];
        core_mem[0] = ~exp_sh[0];
        run_check(1'b1, 0, 0, 30, high, moves);
        checks++;
        if (high != 30) begin errors++; $display("FAIL reset_scan_len: got %0d want 30", high); end
        @(negedge clk);
        checks++;
        if ({pause_cpu, ioctl_upload_req, dirty, nvram_address, ioctl_din} !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid_scan: pause=%b req=%b dirty=%b addr=%h din=%h want all 0",
                     pause_cpu, ioctl_upload_req, dirty, nvram_address, ioctl_din);
        end
        reset_n = 1'b1;
        exp_dirty = 1'b0; exp_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pause_cpu, ioctl_upload_req, dirty} !== 3'b000) begin
            errors++; $display("FAIL post_reset_idle: pause=%b req=%b dirty=%b want 000", pause_cpu, ioctl_upload_req, dirty);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) core_mem[k] = 8'h00;
        test_reset();
        test_download(1'b0);
        test_upload();
        test_autosave_off();
        test_scan_clean();
        test_scan_dirty();
        test_download_abort();
        test_upload();
        test_timeout();
        test_blank();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
